load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 10: byte-address width; SHALL match the data memory address width.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_half  input  1  1 = 16-bit access, 0 = 8-bit access.
REQ-008 req_addr  input  ADDR_W  byte address of the low byte.
REQ-009 req_wdata  input  16  store data; only [7:0] used when req_half=0.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  response consumer ready.
REQ-012 rsp_rdata  output  16  load data; 0 for stores.
REQ-013 mem_we  output  1  drives the memory WriteEn.
REQ-014 mem_re  output  1  drives the memory ReadEn.
REQ-015 mem_addr  output  ADDR_W  drives the memory Address.
REQ-016 mem_wdata  output  8  drives the memory WriteData.
REQ-017 mem_rdata  input  8  from the memory ReadData; valid one cycle after a cycle with mem_re=1.

Function
REQ-018 FSM states: IDLE, ACC_LO, ACC_HI, CAP, RESP. mem_* outputs SHALL be decoded from the state and the latched request only.
REQ-019 IDLE: req_ready=1. On req_valid=1, the unit SHALL latch write/half/addr/wdata and go to ACC_LO. In every other state, req_ready=0.
REQ-020 ACC_LO: mem_addr=addr, mem_wdata=wdata[7:0], mem_we=write, mem_re=~write.
REQ-021 ACC_HI: mem_addr=(addr+1) mod 2^ADDR_W (1023 wraps to 0), mem_wdata=wdata[15:8], mem_we=write, mem_re=~write.
REQ-022 Transitions from ACC_LO: half -> ACC_HI; byte load -> CAP; byte store -> RESP.
REQ-023 Transitions from ACC_HI: load -> CAP, capturing mem_rdata into rdata[7:0] at the exit edge; store -> RESP.
REQ-024 CAP: mem_we=mem_re=0. At the exit edge the unit SHALL capture mem_rdata into rdata[15:8] for half loads or rdata[7:0] for byte loads, then go to RESP. Byte loads SHALL set rdata[15:8]=0 (see REQ-032).
REQ-025 RESP: rsp_valid=1 and rsp_rdata is held stable until rsp_ready=1; that edge returns the FSM to IDLE. rsp_valid=0 in all other states.
REQ-026 Latency from the accepting edge to rsp_valid high: byte store 1 edge, half store 2, byte load 2, half load 3. With rsp_ready held at 1, throughput SHALL be one request per latency+2 cycles.
REQ-027 Little-endian: the low byte SHALL be at addr and the high byte at addr+1. Unaligned addresses SHALL be legal.
REQ-028 mem_we and mem_re SHALL never both be 1.
REQ-029 Stores SHALL drive rsp_rdata=16'h0000.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, rdata=0, and latched request=0. Consequently req_ready=1 and rsp_valid=mem_we=mem_re=0 with no clock edge required.
REQ-031 Reset mid-operation SHALL abandon the access with no response. A half store interrupted after ACC_LO leaves the low byte written; memory contents are not reset.

Configuration
REQ-032 Macro LSU_SIGN_EXT_EN defined: the unit SHALL add input req_signed (1 bit, latched with the request). A byte load with req_signed=1 SHALL set rdata[15:8] to eight copies of the loaded bit 7; otherwise rdata[15:8]=0. Macro undefined: req_signed SHALL be absent and byte loads SHALL always be zero-extended.

Verification
REQ-033 Half store addr=5, wdata=16'hA161, then half load addr=5 -> memory writes [5]=8'h61, [6]=8'hA1; load rsp_rdata=16'hA161 three edges after accept.
REQ-034 Byte store addr=1023, wdata=8'h97, then half store addr=1023, wdata=16'h1234 -> [1023]=8'h34, [0]=8'h12 (wrap); a half load at addr 1023 returns 16'h1234.
REQ-035 Byte load of 8'h97 -> rsp_rdata=16'h0097; with LSU_SIGN_EXT_EN and req_signed=1 -> 16'hFF97.
REQ-036 rsp_ready held 0 for 4 cycles during RESP -> rsp_valid and rsp_rdata stay stable and req_ready=0; a new req_valid is not accepted until the cycle after rsp_ready=1.
REQ-037 rst pulsed during ACC_HI of a half store -> outputs go to reset values asynchronously; only the low byte is written; the next request completes normally.
REQ-038 Every cycle of every test: a bench assertion fails if mem_we and mem_re are both 1.

Source files
------------

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Turns 8-bit and 16-bit load/store requests into a sequence of byte
//   accesses on an 8-bit synchronous-read data memory. 16-bit accesses are
//   little-endian: the low byte lives at addr, the high byte at addr+1
//   (the address wraps modulo 2^ADDR_W). Unaligned addresses are legal.
//
// Ports:
//   clk, rst      - clock; asynchronous active-high reset
//   req_valid     - request present
//   req_ready     - unit idle and able to accept a request
//   req_write     - 1 = store, 0 = load
//   req_half      - 1 = 16-bit access, 0 = 8-bit access
//   req_addr      - byte address of the low byte
//   req_wdata     - store data ([7:0] only for byte stores)
//   req_signed    - (LSU_SIGN_EXT_EN only) sign-extend byte loads
//   rsp_valid     - response present, held until rsp_ready
//   rsp_ready     - response consumer ready
//   rsp_rdata     - load data; 16'h0000 for stores
//   mem_we/mem_re - memory write / read enables (never both high)
//   mem_addr      - memory byte address
//   mem_wdata     - memory write data
//   mem_rdata     - memory read data, valid one cycle after mem_re
//
// Configuration:
//   LSU_SIGN_EXT_EN - when defined, adds req_signed and sign-extends byte
//                     loads that request it; otherwise byte loads are
//                     always zero-extended.
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_half,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
`ifdef LSU_SIGN_EXT_EN
  input  logic              req_signed,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_LO = 3'd1,
    ACC_HI = 3'd2,
    CAP    = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t state, state_nx;

  // Latched request
  logic              lat_write;
  logic              lat_half;
  logic [ADDR_W-1:0] lat_addr;
  logic [15:0]       lat_wdata;
  logic              lat_signed;

  // Assembled load result; cleared on accept so stores respond with zero
  logic [15:0]       rdata;

  // Upper byte for a byte load: replicated bit 7 when signed, else zero
  function automatic logic [7:0] ext_hi(input logic [7:0] b, input logic sgn);
    ext_hi = sgn ? {8{b[7]}} : 8'h00;
  endfunction

`ifdef LSU_SIGN_EXT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_signed <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      lat_signed <= req_signed;
    end
  end
`else
  assign lat_signed = 1'b0;
`endif

  // State register, request latch and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_write <= 1'b0;
      lat_half  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= 16'h0000;
      rdata     <= 16'h0000;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_half  <= req_half;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            rdata     <= 16'h0000;
          end
        end
        // Low byte of a half load arrives while the high byte is being read
        ACC_HI: begin
          if (!lat_write) begin
            rdata[7:0] <= mem_rdata;
          end
        end
        CAP: begin
          if (lat_half) begin
            rdata[15:8] <= mem_rdata;
          end else begin
            rdata[7:0]  <= mem_rdata;
            rdata[15:8] <= ext_hi(mem_rdata, lat_signed);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and output decode (state and latched request only for mem_*)
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata[7:0];
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nx = ACC_LO;
        end
      end
      ACC_LO: begin
        mem_we = lat_write;
        mem_re = ~lat_write;
        if (lat_half) begin
          state_nx = ACC_HI;
        end else if (lat_write) begin
          state_nx = RESP;
        end else begin
          state_nx = CAP;
        end
      end
      ACC_HI: begin
        mem_addr  = lat_addr + ADDR_W'(1);
        mem_wdata = lat_wdata[15:8];
        mem_we    = lat_write;
        mem_re    = ~lat_write;
        state_nx  = lat_write ? RESP : CAP;
      end
      CAP: begin
        state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign rsp_rdata = rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Purpose:
//   Self-checking bench for load_store_unit. A byte-wide synchronous-read
//   memory model is attached to the mem_* port; a separate reference memory
//   predicts load data. Expected responses are queued when a request is
//   driven and compared when the response handshake occurs.
//
// Ports: none (top-level bench).
// Configuration: honours LSU_SIGN_EXT_EN (drives req_signed when defined).
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_half;
  logic [9:0]  req_addr;
  logic [15:0] req_wdata;
`ifdef LSU_SIGN_EXT_EN
  logic        req_signed;
  localparam bit SIGN_EN = 1'b1;
`else
  localparam bit SIGN_EN = 1'b0;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        mem_we;
  logic        mem_re;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem     [0:1023];
  logic [7:0]  ref_mem [0:1023];
  logic [15:0] exp_q [$];

  int tests = 0;
  int fails = 0;

  load_store_unit #(.ADDR_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_half  (req_half),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef LSU_SIGN_EXT_EN
    .req_signed(req_signed),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: write on mem_we, registered read on mem_re
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Write and read enables must be mutually exclusive every cycle
  always @(negedge clk) begin
    chk("we_re_excl", {31'd0, mem_we & mem_re}, 32'd0);
  end

  // Scoreboard: pop and compare on every response handshake
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      chk("rsp_pending", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  // Issue one request; hold = cycles to keep rsp_ready low once in RESP
  task automatic do_req(input logic wr, input logic hf, input logic [9:0] a,
                        input logic [15:0] wd, input logic sg, input int hold);
    logic [9:0]  a1;
    logic [15:0] exp;
    logic [7:0]  lo;
    int n;
    int lat;
    a1  = a + 10'd1;
    lat = wr ? (hf ? 2 : 1) : (hf ? 3 : 2);
    if (wr) begin
      ref_mem[a] = wd[7:0];
      if (hf) ref_mem[a1] = wd[15:8];
      exp = 16'h0000;
    end else if (hf) begin
      exp = {ref_mem[a1], ref_mem[a]};
    end else begin
      lo  = ref_mem[a];
      exp = {(SIGN_EN && sg && lo[7]) ? 8'hFF : 8'h00, lo};
    end
    exp_q.push_back(exp);
    rsp_ready = (hold == 0);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_half  = hf;
    req_addr  = a;
    req_wdata = wd;
`ifdef LSU_SIGN_EXT_EN
    req_signed = sg;
`endif
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
    n = 0;
    while (!rsp_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, lat);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("hold_rdata", {16'd0, rsp_rdata}, {16'd0, exp});
        chk("hold_ready", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b1;
        @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      chk("hold_valid_last", {31'd0, rsp_valid}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("idle_after_rsp", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      chk("no_accept_in_resp", {31'd0, req_ready}, 32'd1);
      chk("no_rsp_after", {31'd0, rsp_valid}, 32'd0);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_half  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
`ifdef LSU_SIGN_EXT_EN
    req_signed = 1'b0;
`endif
    rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
    chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Preload a small window with known contents
    for (int i = 0; i < 16; i += 2) begin
      do_req(1'b1, 1'b1, 10'(i), 16'(($urandom & 16'hFFFF)), 1'b0, 0);
    end

    // Half store/load round trip
    do_req(1'b1, 1'b1, 10'd5, 16'hA161, 1'b0, 0);
    chk("mem5", {24'd0, mem[5]}, 32'h61);
    chk("mem6", {24'd0, mem[6]}, 32'hA1);
    do_req(1'b0, 1'b1, 10'd5, 16'h0000, 1'b0, 0);

    // Byte access at top address, zero- and sign-extension
    do_req(1'b1, 1'b0, 10'd1023, 16'hEE97, 1'b0, 0);
    chk("mem1023_byte", {24'd0, mem[1023]}, 32'h97);
    do_req(1'b0, 1'b0, 10'd1023, 16'h0000, 1'b0, 0);
    do_req(1'b0, 1'b0, 10'd1023, 16'h0000, 1'b1, 0);

    // Response stall with a competing request held high
    do_req(1'b0, 1'b0, 10'd1023, 16'h0000, 1'b1, 4);

    // Address wrap on a half store
    do_req(1'b1, 1'b1, 10'd1023, 16'h1234, 1'b0, 0);
    chk("mem1023_wrap", {24'd0, mem[1023]}, 32'h34);
    chk("mem0_wrap", {24'd0, mem[0]}, 32'h12);
    do_req(1'b0, 1'b1, 10'd1023, 16'h0000, 1'b0, 0);

    // Reset during ACC_HI of a half store
    do_req(1'b1, 1'b1, 10'd200, 16'h0000, 1'b0, 0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_half  = 1'b1;
    req_addr  = 10'd200;
    req_wdata = 16'hBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("acc_hi_addr", {22'd0, mem_addr}, 32'd201);
    chk("acc_hi_we", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("arst_mem_re", {31'd0, mem_re}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_mem[200] = 8'hEF;
    chk("mem200_lo", {24'd0, mem[200]}, 32'hEF);
    chk("mem201_hi", {24'd0, mem[201]}, 32'h00);
    do_req(1'b0, 1'b1, 10'd200, 16'h0000, 1'b0, 0);

    // Random traffic over the preloaded window and the wrap point
    for (int k = 0; k < 24; k++) begin
      logic [9:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? 10'd1023 : 10'($urandom_range(0, 14));
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
             16'(($urandom & 16'hFFFF)), 1'($urandom_range(0, 1)), 0);
    end

    @(posedge clk); #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
